video_timing_gen: RTL and testbench

- Parametrised successor to the fixed 640x480 image output block.
- Generates HDMI transmitter video timing (DE, HS, VS) and a built-in test pattern for any CEA/VESA mode set by parameters.
- Supports run-time pattern selection, programmable sync polarity, a frame-start marker and pixel coordinates for downstream pixel sources.
- Sits between the pixel-clock source and the HDMI_TX_D/DE/HS/VS pins.

---
 rtl/video_timing_gen.sv | 176 +++++++++++++++++
 tb/tb_video_timing_gen.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Parametrised video timing and test-pattern generator for an HDMI transmitter.
// Produces DE/HS/VS, RGB pattern, frame-start marker and pixel coordinates.
module video_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int HS_POL     = 0,
  parameter int VS_POL     = 0,
  parameter int COLOR_W    = 8,
  parameter int CHECK_LOG2 = 5,
  parameter int CNT_W      = 12
) (
  input  logic                 clock_pixel,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [3:0]           mode,
  input  logic [3*COLOR_W-1:0] solid_rgb,
  output logic                 data_enable,
  output logic                 horz_sync,
  output logic                 vert_sync,
  output logic [COLOR_W-1:0]   red,
  output logic [COLOR_W-1:0]   green,
  output logic [COLOR_W-1:0]   blue,
  output logic                 frame_start,
  output logic [CNT_W-1:0]     x,
  output logic [CNT_W-1:0]     y
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BAR_W   = H_ACTIVE / 8;

  localparam logic [CNT_W-1:0] H_ACT_C = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] B_LAST  = CNT_W'(BAR_W - 1);

  localparam logic HS_ON = 1'(HS_POL);
  localparam logic VS_ON = 1'(VS_POL);

  localparam logic [COLOR_W-1:0] C_ONE = {COLOR_W{1'b1}};

  logic                 run_q;
  logic [CNT_W-1:0]     h_cnt;
  logic [CNT_W-1:0]     v_cnt;
  logic [CNT_W-1:0]     bar_cnt;
  logic [2:0]           bar_idx;
  logic [3:0]           mode_q;

  logic                 at_origin;
  logic                 h_wrap;
  logic                 v_wrap;
  logic                 advance;
  logic                 active;
  logic                 hs_act;
  logic                 vs_act;
  logic                 chk;
  logic [3:0]           mode_eff;
  logic [3*COLOR_W-1:0] pix_rgb;

  assign at_origin = (h_cnt == '0) && (v_cnt == '0);
  assign h_wrap    = (h_cnt == H_LAST);
  assign v_wrap    = (v_cnt == V_LAST);
  assign advance   = enable && run_q;

  // The first pixel of a frame already uses the mode being latched now.
  assign mode_eff = at_origin ? mode : mode_q;

  always_ff @(posedge clock_pixel or negedge reset) begin
    if (!reset) begin
      run_q   <= 1'b0;
      h_cnt   <= '0;
      v_cnt   <= '0;
      bar_cnt <= '0;
      bar_idx <= '0;
      mode_q  <= '0;
    end else if (!enable) begin
      run_q   <= 1'b0;
      h_cnt   <= '0;
      v_cnt   <= '0;
      bar_cnt <= '0;
      bar_idx <= '0;
    end else begin
      run_q <= 1'b1;
      if (at_origin) begin
        mode_q <= mode;
      end
      if (run_q) begin
        if (h_wrap) begin
          h_cnt   <= '0;
          bar_cnt <= '0;
          bar_idx <= '0;
          v_cnt   <= v_wrap ? '0 : v_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
          if (bar_cnt == B_LAST) begin
            bar_cnt <= '0;
            if (bar_idx != 3'd7) begin
              bar_idx <= bar_idx + 3'd1;
            end
          end else begin
            bar_cnt <= bar_cnt + 1'b1;
          end
        end
      end
    end
  end

  assign active = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
  assign hs_act = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
  assign vs_act = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
  assign chk    = h_cnt[CHECK_LOG2] ^ v_cnt[CHECK_LOG2];

  // Bar colour bits: R off for idx 2,3,6,7; G off for 4..7; B off on odd idx.
  always_comb begin
    pix_rgb = '0;
    unique case (1'b1)
      (mode_eff == 4'd0): begin
        pix_rgb = {{COLOR_W{~bar_idx[1]}},
                   {COLOR_W{~bar_idx[2]}},
                   {COLOR_W{~bar_idx[0]}}};
      end
      (mode_eff == 4'd1): begin
        pix_rgb = chk ? '0 : {C_ONE, C_ONE, C_ONE};
      end
      (mode_eff == 4'd2): begin
        pix_rgb = {3{h_cnt[COLOR_W-1:0]}};
      end
      (mode_eff == 4'd3): begin
        pix_rgb = solid_rgb;
      end
      default: begin
        pix_rgb = '0;
      end
    endcase
  end

  always_ff @(posedge clock_pixel or negedge reset) begin
    if (!reset) begin
      data_enable        <= 1'b0;
      horz_sync          <= ~HS_ON;
      vert_sync          <= ~VS_ON;
      {red, green, blue} <= '0;
      frame_start        <= 1'b0;
      x                  <= '0;
      y                  <= '0;
    end else if (!advance) begin
      data_enable        <= 1'b0;
      horz_sync          <= ~HS_ON;
      vert_sync          <= ~VS_ON;
      {red, green, blue} <= '0;
      frame_start        <= 1'b0;
      x                  <= '0;
      y                  <= '0;
    end else begin
      data_enable        <= active;
      horz_sync          <= hs_act ? HS_ON : ~HS_ON;
      vert_sync          <= vs_act ? VS_ON : ~VS_ON;
      {red, green, blue} <= active ? pix_rgb : '0;
      frame_start        <= at_origin;
      x                  <= h_cnt;
      y                  <= v_cnt;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomised scoreboard bench for video_timing_gen on a small video mode.
// Reference model tracks a linear pixel position within the frame.
module tb_video_timing_gen;

  localparam int HA  = 44;
  localparam int HF  = 4;
  localparam int HSW = 6;
  localparam int HB  = 5;
  localparam int VA  = 20;
  localparam int VF  = 2;
  localparam int VSW = 3;
  localparam int VB  = 2;
  localparam int HT  = HA + HF + HSW + HB;
  localparam int VT  = VA + VF + VSW + VB;
  localparam int FRAME = HT * VT;
  localparam int BARW  = HA / 8;
  localparam int CL    = 2;
  localparam logic HP = 1'b0;
  localparam logic VP = 1'b1;

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic [23:0] rgb;
    logic        fs;
    logic [11:0] x;
    logic [11:0] y;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [3:0]  mode;
  logic [23:0] solid_rgb;
  logic        de, hs, vs, fs;
  logic [7:0]  red, green, blue;
  logic [11:0] x, y;
  obs_t        act;

  obs_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   started = 1'b0;

  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  logic [3:0]  modes [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 4'd3, 4'd9, 4'd15};

  bit          m_run = 1'b0;
  int          m_p = 0;
  logic [3:0]  m_mode = 4'd0;
  bit          prev_rst = 1'b0;

  always #5 clk = ~clk;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(0), .VS_POL(1), .COLOR_W(8), .CHECK_LOG2(CL), .CNT_W(12)
  ) dut (
    .clock_pixel(clk),
    .reset(reset),
    .enable(enable),
    .mode(mode),
    .solid_rgb(solid_rgb),
    .data_enable(de),
    .horz_sync(hs),
    .vert_sync(vs),
    .red(red),
    .green(green),
    .blue(blue),
    .frame_start(fs),
    .x(x),
    .y(y)
  );

  assign act = {de, hs, vs, red, green, blue, fs, x, y};

  function automatic obs_t idle();
    obs_t o;
    o = '0;
    o.hs = ~HP;
    o.vs = ~VP;
    return o;
  endfunction

  function automatic obs_t model_px(int p, logic [3:0] me, logic [23:0] sd);
    obs_t o;
    int h, v, bi;
    logic [7:0] g;
    h = p % HT;
    v = p / HT;
    o = '0;
    o.de = (h < HA) && (v < VA);
    o.hs = (h >= HA + HF && h < HA + HF + HSW) ? HP : ~HP;
    o.vs = (v >= VA + VF && v < VA + VF + VSW) ? VP : ~VP;
    o.fs = (p == 0);
    o.x  = 12'(h);
    o.y  = 12'(v);
    if (o.de) begin
      case (me)
        4'd0: begin
          bi = h / BARW;
          if (bi > 7) bi = 7;
          o.rgb = bars[bi];
        end
        4'd1: o.rgb = ((((h >> CL) ^ (v >> CL)) & 1) != 0) ? 24'h0 : 24'hFFFFFF;
        4'd2: begin
          g = 8'(h);
          o.rgb = {g, g, g};
        end
        4'd3: o.rgb = sd;
        default: o.rgb = 24'h0;
      endcase
    end
    return o;
  endfunction

  task automatic check(string nm, obs_t a, obs_t e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s t=%0t: got de=%b hs=%b vs=%b rgb=%h fs=%b x=%0d y=%0d, want de=%b hs=%b vs=%b rgb=%h fs=%b x=%0d y=%0d",
               nm, $time, a.de, a.hs, a.vs, a.rgb, a.fs, a.x, a.y,
               e.de, e.hs, e.vs, e.rgb, e.fs, e.x, e.y);
    end
  endtask

  task automatic step(bit rst, bit en, logic [3:0] md, logic [23:0] sd);
    obs_t e;
    logic [3:0] me;
    @(negedge clk);
    enable    = en;
    mode      = md;
    solid_rgb = sd;
    if (rst) begin
      reset = 1'b1;
    end else begin
      #2 reset = 1'b0;
      #1;
      if (prev_rst) check("async_rst", act, idle());
    end
    prev_rst = rst;
    if (!rst) begin
      m_run = 1'b0; m_p = 0; m_mode = 4'd0;
      e = idle();
    end else if (!en) begin
      m_run = 1'b0; m_p = 0;
      e = idle();
    end else if (!m_run) begin
      m_run = 1'b1;
      m_mode = md;
      e = idle();
    end else begin
      me = (m_p == 0) ? md : m_mode;
      e = model_px(m_p, me, sd);
      if (m_p == 0) m_mode = md;
      m_p = (m_p + 1) % FRAME;
    end
    exp_q.push_back(e);
    started = 1'b1;
  endtask

  initial begin
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        if (started) begin
          n_chk++;
          n_fail++;
          $display("FAIL underflow t=%0t: got empty queue, want entry", $time);
        end
      end else begin
        e = exp_q.pop_front();
        check("pixel", act, e);
      end
    end
  end

  initial begin
    int rst_left, dis_left;
    logic [3:0]  md;
    logic [23:0] sd;
    reset = 1'b0; enable = 1'b0; mode = 4'd0; solid_rgb = 24'h0;
    md = 4'd0; sd = 24'h123456;
    rst_left = 0; dis_left = 0;
    repeat (3) step(1'b0, 1'b1, md, sd);
    for (int i = 0; i < 26000; i++) begin
      if (i == 3300) md = 4'd1;
      if (i == 5000) md = 4'd2;
      if (i > 6600 && $urandom_range(0, 299) == 0) md = modes[$urandom_range(0, 7)];
      if ($urandom_range(0, 999) == 0) sd = 24'($urandom);
      if (i == 1700 || i == 8000) rst_left = 2;
      if (i > 6600 && rst_left == 0 && $urandom_range(0, 3999) == 0)
        rst_left = $urandom_range(1, 3);
      if (i == 2500) dis_left = 5;
      if (i > 6600 && dis_left == 0 && $urandom_range(0, 2999) == 0)
        dis_left = $urandom_range(1, 20);
      step(rst_left == 0, dis_left == 0, md, sd);
      if (rst_left > 0) rst_left--;
      if (dis_left > 0) dis_left--;
    end
    @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
